// File: rtl/dmemory_ctrl.sv
// Byte-addressable MIPS data memory with sub-word loads/stores, error reporting,
// a valid/ready request port and an optional post-reset clear of the array.
module dmemory_ctrl #(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 1024,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    INIT,
    IDLE
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  state_t        state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic          clear_we;

  logic          accept;
  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic          bad_size, misaligned, out_of_range, req_err;

  logic [3:0]      st_be;
  logic [3:0][7:0] st_data;

  logic [3:0][7:0] mem [DEPTH];
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [3:0]      mem_be;
  logic [3:0][7:0] mem_wdata;
  logic [3:0][7:0] rd_word;

  logic        rsp_load_q;
  logic [1:0]  rsp_size_q;
  logic        rsp_unsigned_q;
  logic [1:0]  rsp_lane_q;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // NOTE: every signal driven in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    req_ready = 1'b0;
    clear_we  = 1'b0;
    case (state_q)
      INIT: begin
        if (CLEAR_ON_RESET) begin
          clear_we  = 1'b1;
          clr_idx_d = clr_idx_q + 1'b1;
          if (clr_idx_q == AW'(DEPTH - 1)) state_d = IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      IDLE:    req_ready = 1'b1;
      default: state_d = INIT;
    endcase
  end

  assign accept       = req_valid & req_ready;
  assign word_idx     = req_addr[AW+1:2];
  assign lane         = req_addr[1:0];
  assign bad_size     = (req_size == SZ_RSVD);
  assign misaligned   = ((req_size == SZ_HALF) && req_addr[0]) ||
                        ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign out_of_range = |req_addr[WIDTH-1:AW+2];
  assign req_err      = bad_size | misaligned | out_of_range;

  // Sub-word store data is replicated across lanes; the byte enables pick the live lanes.
  always_comb begin
    st_be   = 4'b0000;
    st_data = req_wdata;
    case (req_size)
      SZ_BYTE: begin
        st_be   = 4'b0001 << lane;
        st_data = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        st_be   = lane[1] ? 4'b1100 : 4'b0011;
        st_data = {2{req_wdata[15:0]}};
      end
      SZ_WORD: st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase
  end

  always_comb begin
    mem_we    = clear_we | (accept & req_write & ~req_err);
    mem_waddr = clear_we ? clr_idx_q : word_idx;
    mem_be    = clear_we ? 4'b1111 : st_be;
    mem_wdata = clear_we ? '0 : st_data;
  end

  // NOTE: the array and its read register carry no reset; rst_n must leave contents intact and RAM macros have no reset pin.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) mem[mem_waddr][i] <= mem_wdata[i];
      end
    end
    if (accept) rd_word <= mem[word_idx];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= INIT;
      clr_idx_q      <= '0;
      rsp_valid      <= 1'b0;
      rsp_err        <= 1'b0;
      rsp_load_q     <= 1'b0;
      rsp_size_q     <= SZ_BYTE;
      rsp_unsigned_q <= 1'b0;
      rsp_lane_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      rsp_valid <= accept;
      if (accept) begin
        rsp_err        <= req_err;
        rsp_load_q     <= ~req_write & ~req_err;
        rsp_size_q     <= req_size;
        rsp_unsigned_q <= req_unsigned;
        rsp_lane_q     <= lane;
      end
    end
  end

  // Lane selection and extension happen after the read register, so stores and errors force zero.
  always_comb begin
    sel_byte  = rd_word[rsp_lane_q];
    sel_half  = rsp_lane_q[1] ? rd_word[3:2] : rd_word[1:0];
    rsp_rdata = '0;
    if (rsp_load_q) begin
      case (rsp_size_q)
        SZ_BYTE: rsp_rdata = {{24{~rsp_unsigned_q & sel_byte[7]}}, sel_byte};
        SZ_HALF: rsp_rdata = {{16{~rsp_unsigned_q & sel_half[15]}}, sel_half};
        default: rsp_rdata = rd_word;
      endcase
    end
  end

endmodule

// File: tb/tb_dmemory_ctrl.sv
// Self-checking bench for dmemory_ctrl: a byte-array model checked every cycle,
// plus directed requests carrying hand-computed expected responses.
module tb_dmemory_ctrl;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  dmemory_ctrl #(
    .WIDTH         (32),
    .DEPTH         (DEPTH),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: byte-addressed memory, cycles since reset, last response.
  logic [7:0]  mm [4*DEPTH];
  int          cnt = 0;
  bit          ev  = 1'b0;
  bit          er  = 1'b0;
  logic [31:0] ed  = '0;
  int          m_n;
  bit          m_bad;
  logic [31:0] m_v;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt = 0;
      ev  = 1'b0;
      er  = 1'b0;
      ed  = '0;
    end else begin
      if (req_valid && cnt >= DEPTH) begin
        m_n   = (req_size == 2'd0) ? 1 : (req_size == 2'd1) ? 2 : 4;
        m_bad = (req_size == 2'd3) || (req_addr % m_n != 0) || (req_addr >= 4 * DEPTH);
        m_v   = '0;
        if (!m_bad) begin
          for (int k = 0; k < m_n; k++) begin
            if (req_write) mm[req_addr + k] = req_wdata[8*k +: 8];
            else           m_v = m_v | ({24'b0, mm[req_addr + k]} << (8 * k));
          end
          if (!req_write && !req_unsigned && m_n < 4 && m_v[8*m_n-1])
            m_v = m_v | ~((32'd1 << (8 * m_n)) - 32'd1);
        end
        ev = 1'b1;
        er = m_bad;
        ed = (m_bad || req_write) ? 32'h0 : m_v;
      end else begin
        ev = 1'b0;
      end
      if (cnt < DEPTH) begin
        cnt++;
        if (cnt == DEPTH) for (int i = 0; i < 4 * DEPTH; i++) mm[i] = 8'h00;
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_ready", {31'b0, req_ready}, {31'b0, (cnt >= DEPTH)});
    check("cyc_rsp_valid", {31'b0, rsp_valid}, {31'b0, ev});
    check("cyc_rsp_rdata", rsp_rdata, ed);
    check("cyc_rsp_err", {31'b0, rsp_err}, {31'b0, er});
  end

  // Issue one request at a negedge; its response is visible at the next negedge.
  task automatic req(input bit w, input logic [1:0] s, input bit u, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] exp_data, input bit exp_err,
                     input string name);
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = s;
    req_unsigned = u;
    req_addr     = a;
    req_wdata    = d;
    @(negedge clk);
    check({name, "/valid"}, {31'b0, rsp_valid}, 32'd1);
    check({name, "/rdata"}, rsp_rdata, exp_data);
    check({name, "/err"}, {31'b0, rsp_err}, {31'b0, exp_err});
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 40);
  endtask

  int n_wait;

  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    #2 rst_n = 1'b1;

    wait_ready(n_wait);
    check("init_len", n_wait, 32'd16);

    for (int i = 0; i < DEPTH; i++) req(1'b0, 2'b10, 1'b0, 32'(4 * i), '0, 32'h0, 1'b0, "clr_load");

    req(1'b1, 2'b10, 1'b0, 32'h8, 32'h11223344, 32'h0, 1'b0, "st_w8");
    req(1'b1, 2'b00, 1'b0, 32'hA, 32'h000000AA, 32'h0, 1'b0, "st_bA");
    req(1'b0, 2'b10, 1'b0, 32'h8, '0, 32'h11AA3344, 1'b0, "ld_w8");
    req(1'b0, 2'b00, 1'b0, 32'hA, '0, 32'hFFFFFFAA, 1'b0, "ld_bA_s");
    req(1'b0, 2'b00, 1'b1, 32'hA, '0, 32'h000000AA, 1'b0, "ld_bA_u");
    idle(2);

    req(1'b1, 2'b01, 1'b0, 32'h6, 32'h00008001, 32'h0, 1'b0, "st_h6");
    req(1'b0, 2'b01, 1'b0, 32'h6, '0, 32'hFFFF8001, 1'b0, "ld_h6_s");
    req(1'b0, 2'b01, 1'b1, 32'h6, '0, 32'h00008001, 1'b0, "ld_h6_u");
    req(1'b0, 2'b01, 1'b0, 32'h5, '0, 32'h0, 1'b1, "ld_h5_mis");
    req(1'b0, 2'b10, 1'b0, 32'h4, '0, 32'h80010000, 1'b0, "ld_w4");
    idle(1);

    req(1'b1, 2'b10, 1'b0, 32'h2, 32'hDEADBEEF, 32'h0, 1'b1, "st_w2_mis");
    req(1'b1, 2'b10, 1'b0, 32'(4 * DEPTH), 32'hDEADBEEF, 32'h0, 1'b1, "st_w_oor");
    req(1'b0, 2'b10, 1'b0, 32'h0, '0, 32'h0, 1'b0, "ld_w0");
    idle(1);

    req(1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFEF00D, 32'h0, 1'b0, "b2b_st");
    req(1'b0, 2'b10, 1'b0, 32'h10, '0, 32'hCAFEF00D, 1'b0, "b2b_ld");
    req(1'b0, 2'b11, 1'b0, 32'h0, '0, 32'h0, 1'b1, "size_rsvd");
    req(1'b0, 2'b01, 1'b0, 32'hA, '0, 32'h000011AA, 1'b0, "ld_hA_s");
    req(1'b0, 2'b00, 1'b0, 32'h9, '0, 32'h00000033, 1'b0, "ld_b9_s");
    req(1'b0, 2'b00, 1'b0, 32'hB, '0, 32'h00000011, 1'b0, "ld_bB_s");
    req(1'b0, 2'b00, 1'b0, 32'hFFFFFFFF, '0, 32'h0, 1'b1, "ld_b_oor");
    req(1'b1, 2'b00, 1'b0, 32'h3F, 32'h12345680, 32'h0, 1'b0, "st_b3F");
    req(1'b0, 2'b00, 1'b0, 32'h3F, '0, 32'hFFFFFF80, 1'b0, "ld_b3F_s");
    req(1'b0, 2'b10, 1'b0, 32'h10, '0, 32'hCAFEF00D, 1'b0, "ld_w10");
    idle(2);
    check("hold_rdata", rsp_rdata, 32'hCAFEF00D);
    check("hold_valid", {31'b0, rsp_valid}, 32'd0);

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_ready", {31'b0, req_ready}, 32'd0);
    check("midrst_valid", {31'b0, rsp_valid}, 32'd0);
    check("midrst_rdata", rsp_rdata, 32'h0);
    check("midrst_err", {31'b0, rsp_err}, 32'd0);
    #2 rst_n = 1'b1;
    wait_ready(n_wait);
    check("reinit_len", n_wait, 32'd16);
    req(1'b0, 2'b10, 1'b0, 32'h10, '0, 32'h0, 1'b0, "reclr_w10");
    req(1'b0, 2'b10, 1'b0, 32'h8, '0, 32'h0, 1'b0, "reclr_w8");
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
